// File: rtl/sparse_chunk_buffer.sv
// Purpose : holds one compressed sparse chunk, i.e. a MEM_SIZE-bit sparsemap plus its packed nonzero bytes,
//           and serves windowed sparsemap reads with an inclusive prefix sum.
// Latency : writes commit on the clock edge; all read outputs are combinational with zero latency.
// Backpr. : wr_ready_o drops once MEM_SIZE/BUS_SIZE beats are stored, and beats offered while full are dropped.
//
// Ports:
//   clk_i, rst_i            clock (rising edge) and asynchronous active-low reset
//   wr_sparsemap_i          BUS_SIZE sparsemap bits of a write beat (bit 0 = lowest element)
//   wr_nonzero_data_i       packed nonzero bytes of the beat; lanes 0..popcount-1 are meaningful
//   wr_valid_i/wr_ready_o   write handshake
//   refresh_mem_i           synchronous clear, takes priority over a write in the same cycle
//   rd_addr_i/rd_data_o     1-based nonzero byte index and the byte found there (0 if out of range)
//   rd_ready_o              the whole chunk has been loaded
//   rd_sparsemap_addr_i     window index; rd_sparsemap_o is the selected window
//   prefix_sum_o            inclusive prefix sums of rd_sparsemap_o; element i is the 1-based rank of bit i
module sparse_chunk_buffer #(
   parameter int MEM_SIZE        = 128,
   parameter int BUS_SIZE        = 16,
   parameter int PREFIX_SUM_SIZE = 8
) (
   input  logic                                                  clk_i,
   input  logic                                                  rst_i,
   input  logic [BUS_SIZE-1:0]                                   wr_sparsemap_i,
   input  logic [BUS_SIZE-1:0][7:0]                              wr_nonzero_data_i,
   input  logic                                                  wr_valid_i,
   input  logic                                                  refresh_mem_i,
   output logic                                                  wr_ready_o,
   input  logic [$clog2(MEM_SIZE):0]                             rd_addr_i,
   output logic [7:0]                                            rd_data_o,
   output logic                                                  rd_ready_o,
   input  logic [$clog2(MEM_SIZE/PREFIX_SUM_SIZE)-1:0]           rd_sparsemap_addr_i,
   output logic [PREFIX_SUM_SIZE-1:0]                            rd_sparsemap_o,
   output logic [PREFIX_SUM_SIZE-1:0][$clog2(PREFIX_SUM_SIZE):0] prefix_sum_o
);

   // Derived widths
   localparam int MAW    = $clog2(MEM_SIZE);          // byte / element index width
   localparam int AW     = MAW + 1;                   // width of a count 0..MEM_SIZE
   localparam int NBEATS = MEM_SIZE / BUS_SIZE;       // beats per chunk
   localparam int BIW    = $clog2(NBEATS);            // beat index width
   localparam int BCW    = BIW + 1;                   // beat count width 0..NBEATS
   localparam int BOW    = $clog2(BUS_SIZE);          // element offset inside a beat
   localparam int NCW    = BOW + 1;                   // per-beat nonzero count 0..BUS_SIZE
   localparam int PSB    = $clog2(PREFIX_SUM_SIZE);   // element offset inside a window
   localparam int PSW    = PSB + 1;                   // prefix sum width 0..PREFIX_SUM_SIZE

   // Storage and fill state
   logic [MEM_SIZE-1:0] r_smap;
   logic [7:0]          r_data [MEM_SIZE];
   logic [BCW-1:0]      r_bc;                         // beats stored so far
   logic [AW-1:0]       r_dp;                         // next free data byte

   // Write path
   logic [NCW-1:0]      w_nz_cnt;
   logic                w_accept;
   logic [MAW-1:0]      w_beat_base;

   // Read path
   logic [MAW-1:0]      w_rd_idx;
   logic                w_rd_in_range;
   logic [MAW-1:0]      w_win_base;
   logic [PREFIX_SUM_SIZE-1:0][PSW-1:0] w_ps;

   assign wr_ready_o = (r_bc < BCW'(NBEATS));
   assign rd_ready_o = (r_bc == BCW'(NBEATS));

   // Number of meaningful lanes in this beat
   always_comb begin
      w_nz_cnt = '0;
      for (int k = 0; k < BUS_SIZE; k++) begin
         w_nz_cnt = w_nz_cnt + NCW'(wr_sparsemap_i[k]);
      end
   end

   assign w_accept = wr_valid_i && wr_ready_o && !refresh_mem_i;

   // Beat-aligned sparsemap slot; only valid while not full, which is the only time it is used
   assign w_beat_base = {r_bc[BIW-1:0], {BOW{1'b0}}};

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_smap <= '0;
         for (int i = 0; i < MEM_SIZE; i++) begin
            r_data[i] <= 8'h00;
         end
         r_bc <= '0;
         r_dp <= '0;
      end else if (refresh_mem_i) begin
         r_smap <= '0;
         for (int i = 0; i < MEM_SIZE; i++) begin
            r_data[i] <= 8'h00;
         end
         r_bc <= '0;
         r_dp <= '0;
      end else if (w_accept) begin
         r_smap[w_beat_base +: BUS_SIZE] <= wr_sparsemap_i;
         // Lanes past the popcount carry junk and are never stored. The total nonzero count never
         // exceeds the element count, so DP+k stays inside the memory for every stored lane.
         for (int k = 0; k < BUS_SIZE; k++) begin
            if (NCW'(k) < w_nz_cnt) begin
               r_data[r_dp[MAW-1:0] + MAW'(k)] <= wr_nonzero_data_i[k];
            end
         end
         r_dp <= r_dp + AW'(w_nz_cnt);
         r_bc <= r_bc + BCW'(1);
      end
   end

   // Nonzero byte read: the address is 1-based, so 0 and anything past MEM_SIZE read as 0
   assign w_rd_idx      = MAW'(rd_addr_i - AW'(1));
   assign w_rd_in_range = (rd_addr_i != '0) && (rd_addr_i <= AW'(MEM_SIZE));
   assign rd_data_o     = w_rd_in_range ? r_data[w_rd_idx] : 8'h00;

   // Sparsemap window read
   assign w_win_base     = {rd_sparsemap_addr_i, {PSB{1'b0}}};
   assign rd_sparsemap_o = r_smap[w_win_base +: PREFIX_SUM_SIZE];

   // Kogge-Stone inclusive prefix sum over the window. Each level adds the partial sum from
   // distance d; walking i downwards means w_ps[i-d] still holds the previous level's value.
   always_comb begin
      for (int i = 0; i < PREFIX_SUM_SIZE; i++) begin
         w_ps[i] = PSW'(rd_sparsemap_o[i]);
      end
      for (int d = 1; d < PREFIX_SUM_SIZE; d = d * 2) begin
         for (int i = PREFIX_SUM_SIZE - 1; i >= d; i--) begin
            w_ps[i] = w_ps[i] + w_ps[i-d];
         end
      end
   end

   assign prefix_sum_o = w_ps;

endmodule

// File: tb/tb_sparse_chunk_buffer.sv
// Purpose : self-checking bench for sparse_chunk_buffer using directed vectors and a few multi-cycle sequences.
// Latency : writes are observed one cycle after the handshake; reads are sampled between clock edges.
// Backpr. : exercises full-buffer drop, refresh priority and asynchronous reset in the middle of a fill.
module tb_sparse_chunk_buffer;

   logic             clk_i;
   logic             rst_i;
   logic [15:0]      wr_sparsemap_i;
   logic [15:0][7:0] wr_nonzero_data_i;
   logic             wr_valid_i;
   logic             refresh_mem_i;
   logic             wr_ready_o;
   logic [7:0]       rd_addr_i;
   logic [7:0]       rd_data_o;
   logic             rd_ready_o;
   logic [3:0]       rd_sparsemap_addr_i;
   logic [7:0]       rd_sparsemap_o;
   logic [7:0][3:0]  prefix_sum_o;
   logic [31:0]      ps_flat;

   assign ps_flat = prefix_sum_o;

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {
      logic [7:0]  addr;
      logic [3:0]  win;
      logic [7:0]  exp_data;
      logic [7:0]  exp_smap;
      logic [31:0] exp_ps;     // nibble i = prefix_sum_o[i]
   } vec_t;

   vec_t tbl_full[8];
   vec_t tbl_sparse[9];

   sparse_chunk_buffer #(
      .MEM_SIZE(128),
      .BUS_SIZE(16),
      .PREFIX_SUM_SIZE(8)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .wr_sparsemap_i(wr_sparsemap_i),
      .wr_nonzero_data_i(wr_nonzero_data_i),
      .wr_valid_i(wr_valid_i),
      .refresh_mem_i(refresh_mem_i),
      .wr_ready_o(wr_ready_o),
      .rd_addr_i(rd_addr_i),
      .rd_data_o(rd_data_o),
      .rd_ready_o(rd_ready_o),
      .rd_sparsemap_addr_i(rd_sparsemap_addr_i),
      .rd_sparsemap_o(rd_sparsemap_o),
      .prefix_sum_o(prefix_sum_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive one beat at the falling edge and return 1ns after the rising edge that samples it
   task automatic write_beat(input logic [15:0] smap, input logic [127:0] data, input logic refresh);
      @(negedge clk_i);
      wr_sparsemap_i    = smap;
      wr_nonzero_data_i = data;
      wr_valid_i        = 1'b1;
      refresh_mem_i     = refresh;
      @(posedge clk_i);
      #1;
      wr_valid_i    = 1'b0;
      refresh_mem_i = 1'b0;
   endtask

   task automatic apply_vec(input vec_t v, input string tag);
      rd_addr_i           = v.addr;
      rd_sparsemap_addr_i = v.win;
      #1;
      chk({tag, "_data"}, 32'(rd_data_o), 32'(v.exp_data));
      chk({tag, "_smap"}, 32'(rd_sparsemap_o), 32'(v.exp_smap));
      chk({tag, "_psum"}, ps_flat, v.exp_ps);
   endtask

   initial begin
      logic [127:0] beat_dat;

      // Full chunk, byte value = byte index, every window is 8'hFF
      tbl_full[0] = '{8'd1,   4'd0,  8'h00, 8'hFF, 32'h87654321};
      tbl_full[1] = '{8'd2,   4'd1,  8'h01, 8'hFF, 32'h87654321};
      tbl_full[2] = '{8'd64,  4'd7,  8'h3F, 8'hFF, 32'h87654321};
      tbl_full[3] = '{8'd100, 4'd12, 8'h63, 8'hFF, 32'h87654321};
      tbl_full[4] = '{8'd128, 4'd15, 8'h7F, 8'hFF, 32'h87654321};
      tbl_full[5] = '{8'd0,   4'd3,  8'h00, 8'hFF, 32'h87654321};
      tbl_full[6] = '{8'd129, 4'd8,  8'h00, 8'hFF, 32'h87654321};
      tbl_full[7] = '{8'd255, 4'd9,  8'h00, 8'hFF, 32'h87654321};

      // Beats 8001/AA,BB ; 0004/CC ; 00B6/10..14 with junk lanes above the popcount
      tbl_sparse[0] = '{8'd1, 4'd0, 8'hAA, 8'h01, 32'h11111111};
      tbl_sparse[1] = '{8'd2, 4'd1, 8'hBB, 8'h80, 32'h10000000};
      tbl_sparse[2] = '{8'd3, 4'd2, 8'hCC, 8'h04, 32'h11111100};
      tbl_sparse[3] = '{8'd4, 4'd3, 8'h10, 8'h00, 32'h00000000};
      tbl_sparse[4] = '{8'd5, 4'd4, 8'h11, 8'hB6, 32'h54432210};
      tbl_sparse[5] = '{8'd8, 4'd5, 8'h14, 8'h00, 32'h00000000};
      tbl_sparse[6] = '{8'd9, 4'd6, 8'h00, 8'h00, 32'h00000000};
      tbl_sparse[7] = '{8'd6, 4'd0, 8'h12, 8'h01, 32'h11111111};
      tbl_sparse[8] = '{8'd7, 4'd1, 8'h13, 8'h80, 32'h10000000};

      rst_i               = 1'b0;
      wr_sparsemap_i      = '0;
      wr_nonzero_data_i   = '0;
      wr_valid_i          = 1'b0;
      refresh_mem_i       = 1'b0;
      rd_addr_i           = 8'd1;
      rd_sparsemap_addr_i = 4'd0;
      #12;
      rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;

      // Reset state
      chk("rst_wr_ready", 32'(wr_ready_o), 32'd1);
      chk("rst_rd_ready", 32'(rd_ready_o), 32'd0);
      chk("rst_smap",     32'(rd_sparsemap_o), 32'd0);
      chk("rst_data",     32'(rd_data_o), 32'd0);
      chk("rst_psum",     ps_flat, 32'd0);

      // Dense fill: 8 beats of all-ones
      for (int b = 0; b < 8; b++) begin
         for (int k = 0; k < 16; k++) beat_dat[8*k +: 8] = 8'(16*b + k);
         chk("fill_wr_ready", 32'(wr_ready_o), 32'd1);
         write_beat(16'hFFFF, beat_dat, 1'b0);
      end
      chk("full_wr_ready", 32'(wr_ready_o), 32'd0);
      chk("full_rd_ready", 32'(rd_ready_o), 32'd1);
      for (int i = 0; i < 8; i++) apply_vec(tbl_full[i], "full");

      // Beat offered while full is dropped
      write_beat(16'h00FF, {16{8'hEE}}, 1'b0);
      chk("drop_wr_ready", 32'(wr_ready_o), 32'd0);
      chk("drop_rd_ready", 32'(rd_ready_o), 32'd1);
      for (int i = 0; i < 8; i++) apply_vec(tbl_full[i], "drop");

      // Refresh with a simultaneous write: once from full, once from empty
      write_beat(16'hFFFF, {16{8'h5A}}, 1'b1);
      chk("ref1_wr_ready", 32'(wr_ready_o), 32'd1);
      chk("ref1_rd_ready", 32'(rd_ready_o), 32'd0);
      write_beat(16'hFFFF, {16{8'h5A}}, 1'b1);
      rd_addr_i           = 8'd1;
      rd_sparsemap_addr_i = 4'd0;
      #1;
      chk("ref2_wr_ready", 32'(wr_ready_o), 32'd1);
      chk("ref2_rd_ready", 32'(rd_ready_o), 32'd0);
      chk("ref2_smap",     32'(rd_sparsemap_o), 32'd0);
      chk("ref2_data",     32'(rd_data_o), 32'd0);
      chk("ref2_psum",     ps_flat, 32'd0);

      // Sparse beats with junk lanes
      beat_dat = {16{8'hEE}};
      beat_dat[15:0] = 16'hBBAA;
      write_beat(16'h8001, beat_dat, 1'b0);
      beat_dat = {16{8'hEE}};
      beat_dat[7:0] = 8'hCC;
      write_beat(16'h0004, beat_dat, 1'b0);
      beat_dat = {16{8'hEE}};
      beat_dat[39:0] = 40'h14_13_12_11_10;
      write_beat(16'h00B6, beat_dat, 1'b0);
      chk("sparse_wr_ready", 32'(wr_ready_o), 32'd1);
      chk("sparse_rd_ready", 32'(rd_ready_o), 32'd0);
      for (int i = 0; i < 9; i++) apply_vec(tbl_sparse[i], "sparse");

      // Asynchronous reset between clock edges after 3 beats
      rd_addr_i           = 8'd1;
      rd_sparsemap_addr_i = 4'd4;
      #1;
      rst_i = 1'b0;
      #1;
      chk("arst_wr_ready", 32'(wr_ready_o), 32'd1);
      chk("arst_rd_ready", 32'(rd_ready_o), 32'd0);
      chk("arst_smap",     32'(rd_sparsemap_o), 32'd0);
      chk("arst_data",     32'(rd_data_o), 32'd0);
      chk("arst_psum",     ps_flat, 32'd0);
      #1;
      rst_i = 1'b1;

      // Counters restarted: exactly 8 more beats fill the buffer again
      for (int b = 0; b < 8; b++) begin
         chk("refill_rd_ready", 32'(rd_ready_o), 32'd0);
         write_beat(16'h0001, {16{8'(b + 1)}}, 1'b0);
      end
      rd_addr_i           = 8'd8;
      rd_sparsemap_addr_i = 4'd2;
      #1;
      chk("refill_rd_ready_end", 32'(rd_ready_o), 32'd1);
      chk("refill_data8",        32'(rd_data_o), 32'h08);
      chk("refill_smap",         32'(rd_sparsemap_o), 32'h01);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
